// File: rtl/mem_fetch.sv
// mem_fetch: CPU-side initiator for the async ROM/RAM bus.
// Loads the big-endian reset vector, then streams opcode bytes.
module mem_fetch #(
   parameter int unsigned   AW       = 16,
   parameter int unsigned   WAIT     = 1,
   parameter logic [AW-1:0] VEC_ADDR = 16'hFFFE
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          mem_sel,
   output logic [AW-1:0] mem_a,
   input  logic [7:0]    mem_din,
   output logic          byte_valid,
   output logic [7:0]    byte_data,
   output logic [AW-1:0] byte_addr,
   input  logic          byte_ready,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic          vec_done
);

   localparam logic [1:0] S_VEC_HI = 2'd0;
   localparam logic [1:0] S_VEC_LO = 2'd1;
   localparam logic [1:0] S_FETCH  = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;
   localparam logic [3:0] WAIT_C   = 4'(WAIT);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] a_q, a_d;
   logic [AW-1:0] ba_q, ba_d;
   logic [7:0]    bd_q, bd_d;
   logic          sel_q, sel_d;
   logic          bv_q, bv_d;
   logic          vd_q, vd_d;
   logic          done, xfer, stall;
   logic [AW-1:0] pc_nxt, pc_vec;

   assign done   = (cnt_q == WAIT_C);
   assign xfer   = bv_q & byte_ready;
   assign stall  = bv_q & ~byte_ready;
   assign pc_nxt = pc_q + AW'(1);
   assign pc_vec = pc_q | AW'(mem_din);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      a_d     = a_q;
      sel_d   = sel_q;
      bv_d    = bv_q;
      bd_d    = bd_q;
      ba_d    = ba_q;
      vd_d    = vd_q;
      if (xfer) bv_d = 1'b0;
      unique case (state_q)
         S_VEC_HI: begin
            sel_d = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (done) begin
               pc_d    = AW'({mem_din, 8'h00});
               a_d     = VEC_ADDR + AW'(1);
               cnt_d   = '0;
               state_d = S_VEC_LO;
            end
         end
         S_VEC_LO: begin
            cnt_d = cnt_q + 4'd1;
            if (done) begin
               pc_d    = pc_vec;
               a_d     = pc_vec;
               vd_d    = 1'b1;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            // a still-pending byte stalls the capture rather than being overwritten
            if (!done) begin
               cnt_d = cnt_q + 4'd1;
            end else if (!stall) begin
               bv_d  = 1'b1;
               bd_d  = mem_din;
               ba_d  = pc_q;
               pc_d  = pc_nxt;
               cnt_d = '0;
               if (byte_ready) begin
                  a_d = pc_nxt;
               end else begin
                  sel_d   = 1'b0;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (xfer) begin
               a_d     = pc_q;
               sel_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_VEC_HI;
      endcase
      if (redirect && vd_q) begin
         state_d = S_FETCH;
         cnt_d   = '0;
         pc_d    = redirect_pc;
         a_d     = redirect_pc;
         sel_d   = 1'b1;
         bv_d    = 1'b0;
         bd_d    = bd_q;
         ba_d    = ba_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_VEC_HI;
         cnt_q   <= '0;
         pc_q    <= '0;
         a_q     <= VEC_ADDR;
         sel_q   <= 1'b0;
         bv_q    <= 1'b0;
         bd_q    <= '0;
         ba_q    <= '0;
         vd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         sel_q   <= sel_d;
         bv_q    <= bv_d;
         bd_q    <= bd_d;
         ba_q    <= ba_d;
         vd_q    <= vd_d;
      end
   end

   assign mem_sel    = sel_q;
   assign mem_a      = a_q;
   assign byte_valid = bv_q;
   assign byte_data  = bd_q;
   assign byte_addr  = ba_q;
   assign vec_done   = vd_q;

endmodule

// File: tb/tb_mem_fetch.sv
// tb_mem_fetch: two fetchers (WAIT=1 and WAIT=0) on a shared bench ROM,
// checked against a byte-stream reference model plus literal timelines.
module tb_mem_fetch;

   logic        clk;
   logic        rst_n;
   logic        sel  [2];
   logic [15:0] ma   [2];
   logic [7:0]  din  [2];
   logic        bv   [2];
   logic [7:0]  bd   [2];
   logic [15:0] ba   [2];
   logic        rdy  [2];
   logic        rd   [2];
   logic [15:0] rpc  [2];
   logic        vd   [2];
   logic [7:0]  rom  [256];

   int checks = 0;
   int errors = 0;
   int xfers  = 0;

   assign din[0] = rom[ma[0][7:0]];
   assign din[1] = rom[ma[1][7:0]];

   mem_fetch #(.AW(16), .WAIT(1), .VEC_ADDR(16'hFFFE)) u_a (
      .clk(clk), .rst_n(rst_n),
      .mem_sel(sel[0]), .mem_a(ma[0]), .mem_din(din[0]),
      .byte_valid(bv[0]), .byte_data(bd[0]), .byte_addr(ba[0]),
      .byte_ready(rdy[0]), .redirect(rd[0]),
      .redirect_pc(rpc[0]), .vec_done(vd[0])
   );

   mem_fetch #(.AW(16), .WAIT(0), .VEC_ADDR(16'hFFFE)) u_b (
      .clk(clk), .rst_n(rst_n),
      .mem_sel(sel[1]), .mem_a(ma[1]), .mem_din(din[1]),
      .byte_valid(bv[1]), .byte_data(bd[1]), .byte_addr(ba[1]),
      .byte_ready(rdy[1]), .redirect(rd[1]),
      .redirect_pc(rpc[1]), .vec_done(vd[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, req);
      end
   endtask

   task automatic eq(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
      chk(act == req, nm, act, req);
   endtask

   // reference model: expected address of the next accepted byte
   logic [15:0] ea   [2];
   logic        pbv  [2];
   logic        prdy [2];
   logic        prd  [2];
   logic        pvd  [2];
   logic        psel [2];
   logic [7:0]  pbd  [2];
   logic [15:0] pba  [2];
   logic [15:0] pma  [2];
   int          run  [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int  wt;
         bit  held;
         wt = (i == 0) ? 1 : 0;
         if (!rst_n) begin
            ea[i] = {rom[8'hFE], rom[8'hFF]};
            eq($sformatf("rst_addr%0d", i), 32'(ma[i]), 32'hFFFE);
            eq($sformatf("rst_outs%0d", i),
               32'({sel[i], bv[i], vd[i], bd[i], ba[i]}), 32'h0);
         end else begin
            held = pbv[i] && !prdy[i] && !(prd[i] && pvd[i]);
            if (held) begin
               chk(bv[i] && bd[i] == pbd[i] && ba[i] == pba[i],
                   $sformatf("hold%0d", i),
                   32'({bv[i], bd[i], ba[i]}),
                   32'({1'b1, pbd[i], pba[i]}));
            end else if (bv[i]) begin
               chk(psel[i] && pma[i] == ba[i] && run[i] >= wt + 1,
                   $sformatf("access%0d", i),
                   {pma[i], 16'(run[i])}, {ba[i], 16'(wt + 1)});
            end
            if (bv[i] && rdy[i]) begin
               chk(ba[i] == ea[i] && bd[i] == rom[ea[i][7:0]],
                   $sformatf("xfer%0d", i),
                   {ba[i], 8'h00, bd[i]},
                   {ea[i], 8'h00, rom[ea[i][7:0]]});
               ea[i] = ea[i] + 16'd1;
               xfers++;
            end
            if (rd[i] && vd[i]) ea[i] = rpc[i];
         end
         if (rst_n && sel[i] && psel[i] && ma[i] == pma[i])
            run[i] = run[i] + 1;
         else
            run[i] = (rst_n && sel[i]) ? 1 : 0;
         pbv[i]  = rst_n && bv[i];
         prdy[i] = rdy[i];
         prd[i]  = rd[i];
         pvd[i]  = vd[i];
         psel[i] = rst_n && sel[i];
         pbd[i]  = bd[i];
         pba[i]  = ba[i];
         pma[i]  = ma[i];
      end
   end

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rdy[i] = 1'b1;
         rd[i]  = 1'b0;
         rpc[i] = 16'h0;
      end
      for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
      rom[8'hFE] = 8'hFF;
      rom[8'hFF] = 8'h00;
      rom[8'h00] = 8'h4F;
      rom[8'h01] = 8'h4C;
      rom[8'h02] = 8'h86;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // vector fetch and first bytes
      @(negedge clk);
      eq("a_vhi0", 32'(ma[0]), 32'hFFFE);
      eq("b_vhi0", 32'(ma[1]), 32'hFFFE);
      @(negedge clk);
      eq("a_vhi1", 32'(ma[0]), 32'hFFFE);
      eq("a_sel1", 32'(sel[0]), 32'h1);
      eq("b_vlo", 32'(ma[1]), 32'hFFFF);
      @(negedge clk);
      eq("a_vlo0", 32'(ma[0]), 32'hFFFF);
      eq("a_vd0", 32'(vd[0]), 32'h0);
      eq("b_vd", 32'(vd[1]), 32'h1);
      eq("b_pc", 32'(ma[1]), 32'hFF00);
      @(negedge clk);
      eq("a_vlo1", 32'(ma[0]), 32'hFFFF);
      eq("b_by0", 32'({bv[1], bd[1], ba[1]}), 32'({1'b1, 8'h4F, 16'hFF00}));
      @(negedge clk);
      eq("a_vd1", 32'(vd[0]), 32'h1);
      eq("a_pc", 32'(ma[0]), 32'hFF00);
      eq("b_by1", 32'({bv[1], bd[1], ba[1]}), 32'({1'b1, 8'h4C, 16'hFF01}));
      @(negedge clk);
      eq("a_bv_gap", 32'(bv[0]), 32'h0);
      eq("b_by2", 32'({bv[1], bd[1], ba[1]}), 32'({1'b1, 8'h86, 16'hFF02}));
      @(negedge clk);
      eq("a_by0", 32'({bv[0], bd[0], ba[0]}), 32'({1'b1, 8'h4F, 16'hFF00}));

      // backpressure on 4C
      @(posedge clk);
      #1 rdy[0] = 1'b0;
      @(negedge clk);
      eq("a_bv_gap1", 32'(bv[0]), 32'h0);
      eq("a_ff01", 32'(ma[0]), 32'hFF01);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         eq("a_stall", 32'({bv[0], bd[0], ba[0], sel[0]}),
            32'({1'b1, 8'h4C, 16'hFF01, 1'b0}));
      end
      @(posedge clk);
      #1 rdy[0] = 1'b1;
      @(negedge clk);
      eq("a_stall_end", 32'({bv[0], sel[0]}), 32'b10);

      // redirect while FF02 is in flight
      @(posedge clk);
      #1 rd[0] = 1'b1;
      rpc[0] = 16'hFFFF;
      @(negedge clk);
      eq("a_ff02", 32'({ma[0], sel[0], bv[0]}), 32'({16'hFF02, 2'b10}));
      @(posedge clk);
      #1 rd[0] = 1'b0;
      @(negedge clk);
      eq("a_rdir", 32'({ma[0], bv[0]}), 32'({16'hFFFF, 1'b0}));
      @(negedge clk);
      eq("a_no_ff02", 32'(bv[0]), 32'h0);
      @(negedge clk);
      eq("a_rd_by", 32'({bv[0], bd[0], ba[0]}), 32'({1'b1, 8'h00, 16'hFFFF}));
      @(negedge clk);
      eq("a_wrap_a", 32'({ma[0], bv[0]}), 32'({16'h0000, 1'b0}));
      @(negedge clk);
      eq("a_wrap_by", 32'({bv[0], bd[0], ba[0]}), 32'({1'b1, 8'h4F, 16'h0000}));

      // asynchronous reset mid-fetch, then redirect during VEC_LO
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         eq("arst_a", 32'(ma[i]), 32'hFFFE);
         eq("arst_o", 32'({sel[i], bv[i], vd[i], bd[i], ba[i]}), 32'h0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      eq("r_vhi", 32'(ma[0]), 32'hFFFE);
      @(posedge clk);
      @(posedge clk);
      #1 rd[0] = 1'b1;
      rpc[0] = 16'h1234;
      @(negedge clk);
      eq("r_vlo", 32'({ma[0], vd[0]}), 32'({16'hFFFF, 1'b0}));
      @(posedge clk);
      #1 rd[0] = 1'b0;
      @(negedge clk);
      eq("r_vlo_ign", 32'({ma[0], vd[0]}), 32'({16'hFFFF, 1'b0}));
      @(negedge clk);
      eq("r_pc", 32'({ma[0], vd[0]}), 32'({16'hFF00, 1'b1}));
      @(negedge clk);
      @(negedge clk);
      eq("r_by0", 32'({bv[0], bd[0], ba[0]}), 32'({1'b1, 8'h4F, 16'hFF00}));

      // randomized traffic with fresh ROM contents per reset
      for (int r = 0; r < 3; r++) begin
         @(posedge clk);
         #1 rst_n = 1'b0;
         for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
         for (int i = 0; i < 2; i++) rd[i] = 1'b0;
         @(posedge clk);
         #1 rst_n = 1'b1;
         repeat (1500) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
               rdy[i] = ($urandom_range(0, 3) != 0);
               rd[i]  = ($urandom_range(0, 19) == 0);
               if ($urandom_range(0, 3) == 0)
                  rpc[i] = 16'hFFF8 | 16'($urandom_range(0, 7));
               else
                  rpc[i] = 16'($urandom);
            end
         end
      end
      @(negedge clk);
      chk(xfers > 1000, "xfer_count", 32'(xfers), 32'd1000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_fetch.md
Name: mem_fetch

Overview:
- Bus initiator for the CPU-side async memory interface; it drives the address and select lines and samples read data from the ROM/RAM responders.
- After reset it fetches the big-endian reset vector, then streams sequential opcode bytes to the core over a valid/ready handshake.
- It inserts a programmable number of wait states per access to model async memory access time, and supports a PC redirect (jump) from the core.

Parameters:
- AW, 16, address width in bits.
- WAIT, 1, extra cycles the address is held before read data is sampled (0..15).
- VEC_ADDR, 16'hFFFE, address of the reset vector high byte; the low byte is at VEC_ADDR+1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_sel  output  1  memory select; high while an access is in flight.
- mem_a  output  AW  memory address; held stable for the whole access.
- mem_din  input  8  read data from the responder; combinational function of mem_a.
- byte_valid  output  1  opcode byte available.
- byte_data  output  8  opcode byte.
- byte_addr  output  AW  address the opcode byte was fetched from.
- byte_ready  input  1  core accepts the byte (transfer when valid && ready).
- redirect  input  1  single-cycle pulse: load a new PC.
- redirect_pc  input  AW  new fetch address, valid with redirect.
- vec_done  output  1  high once the reset vector has been loaded; stays high until reset.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=VEC_HI, mem_sel=0, mem_a=VEC_ADDR, byte_valid=0, byte_data=0, byte_addr=0, vec_done=0, pc=0, wait counter=0.
- Access timing:
  - On entering an access state, mem_a is set and mem_sel=1; the counter clears.
  - The counter increments each cycle. On the cycle it equals WAIT, mem_din is captured at the clock edge.
  - Each access therefore occupies exactly WAIT+1 cycles with mem_a constant.
- States:
  - VEC_HI: address VEC_ADDR; capture into pc[15:8]; go to VEC_LO.
  - VEC_LO: address VEC_ADDR+1; capture into pc[7:0]; set vec_done=1; go to FETCH.
  - FETCH: address pc; on capture load byte_data=mem_din, byte_addr=pc, byte_valid=1; pc increments modulo 2^AW. Go to HOLD if byte_valid will remain set, else stay in FETCH.
  - HOLD: mem_sel=0, mem_a holds its last value. Return to FETCH on the cycle after the byte is accepted.
- Flow control:
  - A new FETCH access does not begin while byte_valid=1 and byte_ready=0.
  - If byte_ready=1 on the capture cycle of the previous byte, the next access starts the following cycle (back-to-back). Throughput is 1 byte per WAIT+1 cycles when the core never stalls.
  - byte_valid, byte_data and byte_addr are held stable while valid && !ready.
- Redirect (only when vec_done=1; ignored before that):
  - Aborts any in-flight access without capture and clears byte_valid (a pending byte is discarded).
  - Sets pc=redirect_pc; the state is FETCH with the counter cleared on the next cycle.
  - The first access to redirect_pc begins the cycle after the pulse.
  - Redirect coincident with a handshake: the redirect wins and the byte counts as transferred.
  - Redirect coincident with a capture: the capture is discarded.
- PC wrap: after fetching from 2^AW-1 the next address is 0; no error.
- Mid-operation reset: immediate return to the reset values above; the vector is fetched again on release.
- mem_a upper bits pass through unmodified; responders decode only the bits they need.

Test Plan:
- WAIT=1, bench ROM model (8-bit decode; 0xFE->0xFF, 0xFF->0x00, 0x00->0x4F, 0x01->0x4C, 0x02->0x86):
  - After rst_n rise: mem_a=FFFE for 2 cycles, then FFFF for 2 cycles.
  - vec_done rises and pc=FF00.
  - Bytes 4F@FF00, 4C@FF01, 86@FF02 arrive with byte_valid every 2 cycles while byte_ready=1.
- Backpressure: hold byte_ready=0 for 5 cycles on byte 4C.
  - byte_data=4C and byte_addr=FF01 are stable, mem_sel=0.
  - After acceptance, the FF02 access starts the next cycle.
- Redirect: pulse redirect with redirect_pc=FFFF while the FF02 access is mid-flight.
  - FF02 byte is never presented.
  - Next bytes are 00@FFFF then 4F@0000 (wrap).
- Redirect pulsed during VEC_LO: ignored; the fetch still starts at FF00.
- WAIT=0: vector fetched in 2 cycles total; bytes arrive every cycle with byte_ready tied high.
- Assert rst_n low mid-FETCH: outputs return to reset values asynchronously; the vector sequence repeats on release.
